alu_mp_sequencer: RTL

//  Multi-precision front end for alu_nbit in the accumulator processor. Splits

---
 rtl/alu_mp_sequencer_pkg.sv | 30 +++
 rtl/alu_mp_sequencer_alu_nbit.sv | 49 ++++
 rtl/alu_mp_sequencer.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/alu_mp_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_mp_sequencer_pkg
// Purpose  : ALU op codes, sequencer FSM states and a carry-chain helper.
// Revision : 1.0 - initial release
// ============================================================================
package alu_mp_sequencer_pkg;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_OR   = 3'b010;
    localparam logic [2:0] ALU_ORN  = 3'b011;
    localparam logic [2:0] ALU_AND  = 3'b100;
    localparam logic [2:0] ALU_ANDN = 3'b101;
    localparam logic [2:0] ALU_NOTA = 3'b110;
    localparam logic [2:0] ALU_NOTB = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

    // Only the arithmetic ops propagate a carry between words.
    function automatic logic uses_carry(input logic [2:0] op);
        return (op == ALU_ADD) || (op == ALU_SUB);
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_mp_sequencer_alu_nbit.sv
`default_nettype none
// ============================================================================
// Module   : alu_nbit
// Purpose  : Combinational n-bit ALU slice with carry, overflow and zero flags.
// Revision : 1.0 - initial release
// ============================================================================
module alu_nbit
    import alu_mp_sequencer_pkg::*;
#(
    parameter int n = 8
) (
    input  logic [2:0]   ctrl,
    input  logic [n-1:0] in0,
    input  logic [n-1:0] in1,
    input  logic         c_in,
    output logic [n-1:0] out,
    output logic         c_out,
    output logic         V,
    output logic         Z
);

    logic [n-1:0] w_b_eff;
    logic [n:0]   w_sum;

    always_comb begin
        w_b_eff = (ctrl == ALU_SUB) ? ~in1 : in1;
        w_sum   = {1'b0, in0} + {1'b0, w_b_eff} + {{n{1'b0}}, c_in};
        out     = '0;
        c_out   = 1'b0;
        V       = 1'b0;
        case (ctrl)
            ALU_ADD, ALU_SUB: begin
                out   = w_sum[n-1:0];
                c_out = w_sum[n];
                // Signed overflow: like-signed operands giving a result of the other sign.
                V     = (in0[n-1] == w_b_eff[n-1]) && (w_sum[n-1] != in0[n-1]);
            end
            ALU_OR:   out = in0 | in1;
            ALU_ORN:  out = in0 | ~in1;
            ALU_AND:  out = in0 & in1;
            ALU_ANDN: out = in0 & ~in1;
            ALU_NOTA: out = ~in0;
            default:  out = ~in1;
        endcase
        Z = (out == '0);
    end

endmodule
`default_nettype wire

// File: rtl/alu_mp_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu_mp_sequencer
// Purpose  : Runs WORDS*n-bit operations LSW-first through one alu_nbit slice.
// Revision : 1.0 - initial release
// ============================================================================
module alu_mp_sequencer
    import alu_mp_sequencer_pkg::*;
#(
    parameter int n     = 8,
    parameter int WORDS = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [2:0]         op,
    input  logic               c_in,
    input  logic [n*WORDS-1:0] a_in,
    input  logic [n*WORDS-1:0] b_in,
    output logic [n*WORDS-1:0] result,
    output logic               c_out,
    output logic               V,
    output logic               Z,
    output logic               busy,
    output logic               done
);

    localparam int                 c_W     = n * WORDS;
    localparam int                 c_IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [c_IDX_W-1:0] c_LAST  = c_IDX_W'(WORDS - 1);
    localparam logic [c_IDX_W-1:0] c_ONE   = c_IDX_W'(1);

    state_t             r_state;
    state_t             w_state_next;
    logic [c_IDX_W-1:0] r_index;
    logic [2:0]         r_op;
    logic               r_c_in;
    logic [c_W-1:0]     r_a;
    logic [c_W-1:0]     r_b;
    logic [c_W-1:0]     r_result;
    logic               r_carry;
    logic               r_c_out;
    logic               r_v;
    logic               r_z;

    logic [n-1:0]       w_word_a;
    logic [n-1:0]       w_word_b;
    logic [n-1:0]       w_alu_out;
    logic               w_alu_cin;
    logic               w_alu_cout;
    logic               w_alu_v;
    logic               w_alu_z;
    logic               w_accept;
    logic               w_last;

    assign w_accept = (r_state == S_IDLE) && start;
    assign w_last   = (r_index == c_LAST);
    assign w_word_a = r_a[r_index*n +: n];
    assign w_word_b = r_b[r_index*n +: n];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (w_last) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                done         = 1'b1;
                w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Word 0 takes the external carry for ADD and the +1 of two's complement for SUB.
    always_comb begin
        w_alu_cin = 1'b0;
        if (r_index == '0) begin
            if (r_op == ALU_ADD) begin
                w_alu_cin = r_c_in;
            end else if (r_op == ALU_SUB) begin
                w_alu_cin = 1'b1;
            end
        end else if (uses_carry(r_op)) begin
            w_alu_cin = r_carry;
        end
    end

    alu_nbit #(
        .n (n)
    ) u_alu (
        .ctrl  (r_op),
        .in0   (w_word_a),
        .in1   (w_word_b),
        .c_in  (w_alu_cin),
        .out   (w_alu_out),
        .c_out (w_alu_cout),
        .V     (w_alu_v),
        .Z     (w_alu_z)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_index  <= '0;
            r_op     <= '0;
            r_c_in   <= 1'b0;
            r_a      <= '0;
            r_b      <= '0;
            r_result <= '0;
            r_carry  <= 1'b0;
            r_c_out  <= 1'b0;
            r_v      <= 1'b0;
            r_z      <= 1'b0;
        end else if (w_accept) begin
            r_index  <= '0;
            r_op     <= op;
            r_c_in   <= c_in;
            r_a      <= a_in;
            r_b      <= b_in;
            r_result <= '0;
            r_carry  <= 1'b0;
            r_c_out  <= 1'b0;
            r_v      <= 1'b0;
            r_z      <= 1'b1;
        end else if (r_state == S_RUN) begin
            r_result[r_index*n +: n] <= w_alu_out;
            r_carry                  <= w_alu_cout;
            r_z                      <= r_z & w_alu_z;
            if (w_last) begin
                r_v     <= w_alu_v;
                r_c_out <= w_alu_cout;
            end else begin
                r_index <= r_index + c_ONE;
            end
        end
    end

    assign result = r_result;
    assign c_out  = r_c_out;
    assign V      = r_v;
    assign Z      = r_z;

endmodule
`default_nettype wire
